gol_frame_capture: RTL and testbench
====================================

// Module: gol_frame_capture
// PURPOSE
//   Downstream consumer of the Game-of-Life FSM. Watches the FSM state code and serial cell
//   bit, deserialises each generation into a SIDE x SIDE shadow buffer, commits complete
//   frames to a display register and drives a row-scanned LED matrix. Also reports
//   generation count, population and extinction. Same clock domain as the FSM.
// PARAMETERS
//   SIDE      5            grid edge length
//   N         SIDE*SIDE    cells per frame
//   SCAN_DIV  4            clocks per displayed row (>=1)
//   GEN_W     8            generation counter width
// PORTS
//   clock        in   1                clock, all state on rising edge
//   reset_n      in   1                asynchronous, active-low reset
//   state_in     in   2                FSM state code: 00 INPUT, 01 UPDATE, 10 OUTPUT, 11 unused
//   cell_in      in   1                serial cell bit from FSM
//   row_sel      out  SIDE             one-hot active row
//   col_out      out  SIDE             cells of active row, col_out[c] = frame[row*SIDE+c]
//   frame        out  N                committed frame, bit i = row i/SIDE, col i%SIDE
//   frame_valid  out  1                1-cycle pulse on commit
//   frame_abort  out  1                1-cycle pulse on short (aborted) capture
//   gen_count    out  GEN_W            committed frames since reset
//   pop_count    out  $clog2(N+1)      live cells in frame
//   extinct      out  1                frame committed at least once and pop_count == 0
// BEHAVIOUR
//   Reset (async, reset_n=0): frame=0, shadow=0, idx=0, gen_count=0, row_sel=1 (row 0),
//     scan counter=0, frame_valid=frame_abort=extinct=0, capture FSM in IDLE.
//   Capture FSM states: IDLE, CAPTURE, DRAIN.
//     IDLE: state_in==10 -> shadow[0]<=cell_in, idx<=1, go CAPTURE (first OUTPUT cycle = cell 0).
//     CAPTURE: state_in==10 -> shadow[idx]<=cell_in, idx++; when the bit for idx==N-1 is
//       written: frame<=shadow with that bit merged, frame_valid=1 next cycle, gen_count++,
//       go DRAIN. state_in!=10 with idx<N -> shadow discarded, frame unchanged,
//       frame_abort=1 next cycle, go IDLE.
//     DRAIN: ignore cell_in while state_in==10; state_in!=10 -> IDLE.
//   State code 11 is treated as "not OUTPUT" everywhere.
//   Latency: frame, gen_count, pop_count, extinct, frame_valid all update on the clock edge
//     after the N-th bit is sampled; pop_count/extinct are registered alongside frame.
//   gen_count wraps 2^GEN_W-1 -> 0; extinct is not affected by wrap.
//   Row scan free-runs regardless of capture: row advances every SCAN_DIV clocks,
//     row SIDE-1 wraps to row 0; col_out is combinational from frame and current row.
//   Commit coinciding with a row advance: new row shows new frame on the same edge; no
//     tearing inside a row (frame changes only on commit edge).
//   Back-to-back OUTPUT phases with a 1-cycle non-OUTPUT gap each capture independently.
//   Reset asserted mid-capture: everything returns to reset values immediately; no pulse.
// STRUCTURE
//   Shared package gol_pkg: state enum {INPUT=2'b00, UPDATE=2'b01, OUTPUT=2'b10},
//     default SIDE constant, capture FSM enum.
//   One sub-module: gol_row_scanner (SIDE, SCAN_DIV; clock, reset_n -> row index, row_sel).
//   Popcount is a combinational adder tree on the committed value, registered at commit.
// TESTING
//   1. Reset, hold 00, then 10 for 25 cycles with cell_in=1 only at cycles 0,6,12,18,24 ->
//      frame=25'h1041041, frame_valid 1 pulse, gen_count=1, pop_count=5, extinct=0.
//   2. 10 for 12 cycles then 01 -> frame_abort pulse, frame/gen_count unchanged, IDLE.
//   3. 10 for 30 cycles, cell_in=1 on cycles 25..29 -> those bits ignored, one commit only.
//   4. Commit all-zero frame -> pop_count=0, extinct=1; next frame with 3 cells -> extinct=0.
//   5. Frame=glider, SCAN_DIV=4 -> row_sel 00001->00010 after 4 clocks, wraps 10000->00001
//      after 20; col_out matches frame row bits each phase.
//   6. Pull reset_n low at idx=10 of capture -> immediate async clear, no pulses; 256
//      commits from reset -> gen_count=0 after wrap.

Source files
------------

// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gol_pkg
//  Description : Shared types for the Game-of-Life frame capture path:
//                FSM state codes seen on the serial stream, the capture
//                FSM encoding and the default grid edge length.
//  Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

  localparam int GOL_SIDE = 5;

  // State codes broadcast by the Game-of-Life FSM; 2'b11 is unused.
  typedef enum logic [1:0] {
    GOL_INPUT  = 2'b00,
    GOL_UPDATE = 2'b01,
    GOL_OUTPUT = 2'b10
  } gol_state_e;

  // Capture FSM states.
  typedef enum logic [1:0] {
    CAP_IDLE    = 2'b00,
    CAP_CAPTURE = 2'b01,
    CAP_DRAIN   = 2'b10
  } cap_state_e;

endpackage : gol_pkg
`default_nettype wire

// File: rtl/gol_frame_capture_if.sv
`default_nettype none
// ============================================================================
//  Module      : gol_frame_capture_if
//  Description : Serial cell stream from the Game-of-Life FSM: state code
//                plus one cell bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gol_frame_capture_if;

  logic [1:0] state_in;
  logic       cell_in;

  // FSM side drives the stream.
  modport master (output state_in, output cell_in);
  // Capture side consumes it.
  modport slave  (input  state_in, input  cell_in);

endinterface : gol_frame_capture_if
`default_nettype wire

// File: rtl/gol_row_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : gol_row_scanner
//  Description : Free-running LED row scanner. Holds each row for SCAN_DIV
//                clocks, cycles rows 0..SIDE-1 and presents a one-hot select.
//  Revision    : 1.0 - initial release
// ============================================================================
module gol_row_scanner #(
  parameter  int SIDE     = 5,
  parameter  int SCAN_DIV = 4,
  localparam int ROW_W    = (SIDE > 1) ? $clog2(SIDE) : 1,
  localparam int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic [ROW_W-1:0] row_idx,
  output logic [SIDE-1:0]  row_sel
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Divider terminal count advances the row, wrapping after the last one.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    row_d = row_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      row_d = (row_q == ROW_W'(SIDE - 1)) ? '0 : row_q + ROW_W'(1);
    end
  end

  // Divider and row registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      row_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      row_q <= row_d;
    end
  end

  // One-hot decode of the current row.
  always_comb begin
    row_sel          = '0;
    row_sel[row_q]   = 1'b1;
  end

  assign row_idx = row_q;

endmodule : gol_row_scanner
`default_nettype wire

// File: rtl/gol_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module      : gol_frame_capture
//  Description : Deserialises each Game-of-Life generation from the FSM's
//                OUTPUT phase into a shadow buffer, commits complete frames,
//                counts generations/population, flags extinction and drives
//                a row-scanned LED matrix.
//  Revision    : 1.0 - initial release
// ============================================================================
module gol_frame_capture
  import gol_pkg::*;
#(
  parameter  int SIDE     = GOL_SIDE,
  parameter  int SCAN_DIV = 4,
  parameter  int GEN_W    = 8,
  localparam int N        = SIDE * SIDE,
  localparam int POP_W    = $clog2(N + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  gol_frame_capture_if.slave   fsm,
  output logic [SIDE-1:0]      row_sel,
  output logic [SIDE-1:0]      col_out,
  output logic [N-1:0]         frame,
  output logic                 frame_valid,
  output logic                 frame_abort,
  output logic [GEN_W-1:0]     gen_count,
  output logic [POP_W-1:0]     pop_count,
  output logic                 extinct
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = (SIDE > 1) ? $clog2(SIDE) : 1;

  cap_state_e       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [N-1:0]     shadow_q, shadow_d;
  logic [N-1:0]     frame_q,  frame_d;
  logic [GEN_W-1:0] gen_q,    gen_d;
  logic [POP_W-1:0] pop_q,    pop_d;
  logic             ext_q,    ext_d;
  logic             valid_q,  valid_d;
  logic             abort_q,  abort_d;
  logic [ROW_W-1:0] row_idx;
  logic             is_out;

  // Sum of live cells; a flat loop that synthesis folds into an adder tree.
  function automatic logic [POP_W-1:0] popcnt(input logic [N-1:0] v);
    logic [POP_W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + POP_W'(v[i]);
    return s;
  endfunction

  // Code 11 is deliberately not OUTPUT.
  assign is_out = (fsm.state_in == GOL_OUTPUT);

  // Capture FSM: shift cells into the shadow, commit on the last cell,
  // abort on a short OUTPUT phase, ignore overrun cells while draining.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    gen_d    = gen_q;
    pop_d    = pop_q;
    ext_d    = ext_q;
    valid_d  = 1'b0;
    abort_d  = 1'b0;
    case (state_q)
      CAP_IDLE: begin
        if (is_out) begin
          shadow_d    = '0;
          shadow_d[0] = fsm.cell_in;
          idx_d       = IDX_W'(1);
          state_d     = CAP_CAPTURE;
        end
      end
      CAP_CAPTURE: begin
        if (is_out) begin
          shadow_d[idx_q] = fsm.cell_in;
          if (idx_q == IDX_W'(N - 1)) begin
            frame_d = shadow_d;
            gen_d   = gen_q + GEN_W'(1);
            pop_d   = popcnt(shadow_d);
            ext_d   = (pop_d == '0);
            valid_d = 1'b1;
            idx_d   = '0;
            state_d = CAP_DRAIN;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          abort_d = 1'b1;
          idx_d   = '0;
          state_d = CAP_IDLE;
        end
      end
      CAP_DRAIN: begin
        if (!is_out) state_d = CAP_IDLE;
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  // Capture state, committed frame and its statistics.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= CAP_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      frame_q  <= '0;
      gen_q    <= '0;
      pop_q    <= '0;
      ext_q    <= 1'b0;
      valid_q  <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      gen_q    <= gen_d;
      pop_q    <= pop_d;
      ext_q    <= ext_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
    end
  end

  gol_row_scanner #(
    .SIDE     (SIDE),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .row_idx (row_idx),
    .row_sel (row_sel)
  );

  // Active row's cells straight from the committed frame, so a commit shows
  // up on the same edge and a row never mixes two frames.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < SIDE; r++) begin
      if (row_idx == ROW_W'(r)) col_out = frame_q[r*SIDE +: SIDE];
    end
  end

  assign frame       = frame_q;
  assign frame_valid = valid_q;
  assign frame_abort = abort_q;
  assign gen_count   = gen_q;
  assign pop_count   = pop_q;
  assign extinct     = ext_q;

endmodule : gol_frame_capture
`default_nettype wire

// File: tb/tb_gol_frame_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gol_frame_capture
//  Description : Directed, table-driven bench for gol_frame_capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_frame_capture;
  import gol_pkg::*;

  localparam int SIDE     = 5;
  localparam int N        = 25;
  localparam int SCAN_DIV = 4;
  localparam int GEN_W    = 8;
  localparam int POP_W    = 5;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic [SIDE-1:0]  row_sel, col_out;
  logic [N-1:0]     frame;
  logic             frame_valid, frame_abort, extinct;
  logic [GEN_W-1:0] gen_count;
  logic [POP_W-1:0] pop_count;

  gol_frame_capture_if bus ();

  gol_frame_capture #(
    .SIDE     (SIDE),
    .SCAN_DIV (SCAN_DIV),
    .GEN_W    (GEN_W)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fsm         (bus),
    .row_sel     (row_sel),
    .col_out     (col_out),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_abort (frame_abort),
    .gen_count   (gen_count),
    .pop_count   (pop_count),
    .extinct     (extinct)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_valid = 0;
  int n_abort = 0;

  // Pulse counters sampled mid-cycle.
  always @(negedge clock) begin
    if (frame_valid === 1'b1) n_valid <= n_valid + 1;
    if (frame_abort === 1'b1) n_abort <= n_abort + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] s, input logic c);
    bus.state_in = s;
    bus.cell_in  = c;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    bus.state_in = 2'b00;
    bus.cell_in  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic capture(input logic [N-1:0] pat, input int len, input logic extra);
    for (int k = 0; k < len; k++) drive(2'b10, (k < N) ? pat[k] : extra);
  endtask

  typedef struct {
    logic [N-1:0] pat;
    int           len;
    logic         extra;
    logic [1:0]   gap;
    logic [N-1:0] exp_frame;
    int           exp_nv;
    int           exp_na;
    int           exp_gen;
    int           exp_pop;
    logic         exp_ext;
  } vec_t;

  localparam logic [N-1:0] GLIDER = 25'h0001C82;

  vec_t tbl[8];

  initial begin
    int nv0, na0, exp_row;
    logic [N-1:0] gl;

    tbl[0] = '{25'h1041041, 25, 1'b0, 2'b01, 25'h1041041, 1, 0, 1, 5,  1'b0};
    tbl[1] = '{25'h1FFFFFF, 12, 1'b0, 2'b01, 25'h1041041, 0, 1, 1, 5,  1'b0};
    tbl[2] = '{25'h0000003, 30, 1'b1, 2'b00, 25'h0000003, 1, 0, 2, 2,  1'b0};
    tbl[3] = '{25'h0000000, 25, 1'b0, 2'b01, 25'h0000000, 1, 0, 3, 0,  1'b1};
    tbl[4] = '{25'h0000007, 25, 1'b0, 2'b11, 25'h0000007, 1, 0, 4, 3,  1'b0};
    tbl[5] = '{25'h1FFFFFF, 24, 1'b0, 2'b11, 25'h0000007, 0, 1, 4, 3,  1'b0};
    tbl[6] = '{25'h1FFFFFF, 25, 1'b0, 2'b00, 25'h1FFFFFF, 1, 0, 5, 25, 1'b0};
    tbl[7] = '{GLIDER,      25, 1'b0, 2'b00, GLIDER,      1, 0, 6, 5,  1'b0};

    bus.state_in = 2'b00;
    bus.cell_in  = 1'b0;
    do_reset();

    // Reset values
    check("rst frame",   32'(frame),       32'h0);
    check("rst gen",     32'(gen_count),   32'h0);
    check("rst pop",     32'(pop_count),   32'h0);
    check("rst extinct", 32'(extinct),     32'h0);
    check("rst row_sel", 32'(row_sel),     32'h1);
    check("rst valid",   32'(frame_valid), 32'h0);
    check("rst abort",   32'(frame_abort), 32'h0);

    // Row scan timing from reset
    for (int i = 1; i <= 20; i++) begin
      drive(2'b00, 1'b0);
      if (i == 3)  check("scan c3",  32'(row_sel), 32'h01);
      if (i == 4)  check("scan c4",  32'(row_sel), 32'h02);
      if (i == 19) check("scan c19", 32'(row_sel), 32'h10);
      if (i == 20) check("scan c20", 32'(row_sel), 32'h01);
    end

    // Table-driven captures
    for (int i = 0; i < 8; i++) begin
      nv0 = n_valid;
      na0 = n_abort;
      capture(tbl[i].pat, tbl[i].len, tbl[i].extra);
      drive(tbl[i].gap, 1'b0);
      drive(tbl[i].gap, 1'b0);
      check($sformatf("vec%0d frame", i),   32'(frame),       32'(tbl[i].exp_frame));
      check($sformatf("vec%0d valid", i),   32'(n_valid - nv0), 32'(tbl[i].exp_nv));
      check($sformatf("vec%0d abort", i),   32'(n_abort - na0), 32'(tbl[i].exp_na));
      check($sformatf("vec%0d gen", i),     32'(gen_count),   32'(tbl[i].exp_gen));
      check($sformatf("vec%0d pop", i),     32'(pop_count),   32'(tbl[i].exp_pop));
      check($sformatf("vec%0d extinct", i), 32'(extinct),     32'(tbl[i].exp_ext));
    end

    // Glider on the matrix: every row phase shows its frame slice
    gl = GLIDER;
    for (int i = 0; i < 24; i++) begin
      exp_row = (cyc / SCAN_DIV) % SIDE;
      check($sformatf("scan row_sel c%0d", cyc), 32'(row_sel), 32'(1) << exp_row);
      check($sformatf("scan col_out c%0d", cyc), 32'(col_out), 32'((gl >> (exp_row * SIDE)) & 25'h1F));
      drive(2'b00, 1'b0);
    end

    // Back-to-back OUTPUT phases with a single-cycle gap
    nv0 = n_valid;
    capture(25'h0AAAAAA, 25, 1'b0);
    drive(2'b01, 1'b0);
    capture(25'h1555555, 25, 1'b0);
    drive(2'b00, 1'b0);
    drive(2'b00, 1'b0);
    check("b2b valid", 32'(n_valid - nv0), 32'd2);
    check("b2b frame", 32'(frame),         32'h1555555);
    check("b2b gen",   32'(gen_count),     32'd8);
    check("b2b pop",   32'(pop_count),     32'd13);

    // Reset asserted mid-capture clears asynchronously
    capture(25'h1FFFFFF, 10, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst frame",   32'(frame),       32'h0);
    check("arst gen",     32'(gen_count),   32'h0);
    check("arst pop",     32'(pop_count),   32'h0);
    check("arst row_sel", 32'(row_sel),     32'h1);
    check("arst valid",   32'(frame_valid), 32'h0);
    check("arst abort",   32'(frame_abort), 32'h0);
    bus.state_in = 2'b00;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    cyc     = 0;
    nv0 = n_valid;
    na0 = n_abort;
    repeat (3) drive(2'b00, 1'b0);
    check("arst no valid", 32'(n_valid - nv0), 32'd0);
    check("arst no abort", 32'(n_abort - na0), 32'd0);

    // 256 commits wrap the generation counter
    nv0 = n_valid;
    for (int g = 1; g <= 256; g++) begin
      capture(25'h0, 25, 1'b0);
      drive(2'b01, 1'b0);
      if (g == 255) check("wrap gen255", 32'(gen_count), 32'd255);
    end
    drive(2'b00, 1'b0);
    check("wrap gen0",    32'(gen_count),     32'd0);
    check("wrap extinct", 32'(extinct),       32'd1);
    check("wrap commits", 32'(n_valid - nv0), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_gol_frame_capture
`default_nettype wire
